// File: rtl/int_pe_result_drain_pkg.sv
// int_pe_result_drain_pkg: types and helpers shared by the PE row and its result drain
//   drain_state_e : drain FSM states
//   pe_acc_width  : accumulator width of a PE from its operand widths
package int_pe_result_drain_pkg;
    typedef enum logic {IDLE, STREAM} drain_state_e;
    function automatic int pe_acc_width(input int wa, input int wb);
        return wa + wb;
    endfunction
endpackage

// File: rtl/int_pe_result_drain_if.sv
// int_pe_result_drain_if: valid/ready result stream, one drained PE accumulator per beat
//   valid/ready : beat handshake
//   data        : accumulator value, index : PE number, last : final PE, ovf : PE overflowed
//   master drives the stream, slave consumes it
interface int_pe_result_drain_if #(
    parameter int W_OUT_X = 24,
    parameter int W_IDX   = 3
);
    logic               valid;
    logic               ready;
    logic [W_OUT_X-1:0] data;
    logic [W_IDX-1:0]   index;
    logic               last;
    logic               ovf;
    modport master (output valid, data, index, last, ovf, input ready);
    modport slave  (input valid, data, index, last, ovf, output ready);
endinterface

// File: rtl/int_pe_result_drain.sv
// int_pe_result_drain: snapshots a row of PE accumulators on start, clears the PEs, streams the snapshot out
//   clk, rstn (async, active-low)
//   start       : capture request, honoured only in IDLE
//   pe_out_x    : NUM_PE accumulators, PE i at [i*W_OUT_X +: W_OUT_X]
//   pe_overflow : per-PE overflow pulses, collected into sticky flags
//   pe_set_zero : one-cycle clear to all PEs, the cycle after capture
//   busy        : streaming; err_drop : start ignored while busy (one cycle later)
//   m           : result stream (master)
//   PE_DRAIN_SAT_EN : when defined, overflowed beats present all-ones data
module int_pe_result_drain
    import int_pe_result_drain_pkg::*;
#(
    parameter  int NUM_PE  = 8,
    parameter  int W_IN_A  = 8,
    parameter  int W_IN_B  = 16,
    localparam int W_OUT_X = pe_acc_width(W_IN_A, W_IN_B),
    localparam int W_IDX   = $clog2(NUM_PE)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [NUM_PE*W_OUT_X-1:0] pe_out_x,
    input  logic [NUM_PE-1:0]         pe_overflow,
    output logic                      pe_set_zero,
    output logic                      busy,
    output logic                      err_drop,
    int_pe_result_drain_if.master     m
);
    localparam logic [W_IDX-1:0] LAST = W_IDX'(NUM_PE - 1);

    drain_state_e       state, state_nxt;
    logic [W_IDX-1:0]   idx;
    logic [W_OUT_X-1:0] shadow [NUM_PE];
    logic [NUM_PE-1:0]  ovf_sticky, ovf_shadow;
    logic               capture, hs;

    assign capture = state == IDLE && start;
    assign hs      = state == STREAM && m.ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (start ? STREAM : IDLE) : (hs && idx == LAST ? IDLE : STREAM);
    end

    always_comb begin
        busy    = state == STREAM;
        m.valid = busy;
        m.index = idx;
        m.last  = busy && idx == LAST;
        m.ovf   = busy && ovf_shadow[idx];
`ifdef PE_DRAIN_SAT_EN
        m.data  = !busy ? '0 : ovf_shadow[idx] ? '1 : shadow[idx];
`else
        m.data  = busy ? shadow[idx] : '0;
`endif
    end

    // An overflow arriving in the capture cycle belongs to the snapshot, so
    // the sticky vector restarts empty for the next accumulation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx         <= '0;
            ovf_sticky  <= '0;
            ovf_shadow  <= '0;
            pe_set_zero <= 1'b0;
            err_drop    <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) shadow[i] <= '0;
        end else begin
            pe_set_zero <= capture;
            err_drop    <= start && state == STREAM;
            ovf_sticky  <= capture ? '0 : ovf_sticky | pe_overflow;
            if (capture) begin
                ovf_shadow <= ovf_sticky | pe_overflow;
                for (int i = 0; i < NUM_PE; i++) shadow[i] <= pe_out_x[i*W_OUT_X +: W_OUT_X];
            end
            if (hs) idx <= idx == LAST ? '0 : idx + 1'b1;
        end
    end
endmodule
